// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared geometry, colour constants and pixel types for the Mush-Jump datapath
package game_pkg;

   typedef logic [7:0] x_t;
   typedef logic [6:0] y_t;
   typedef logic [2:0] colour_t;

   typedef struct packed {
      x_t      x;
      y_t      y;
      colour_t colour;
   } pixel_t;

   localparam int H_RES       = 160;
   localparam int V_RES       = 120;
   localparam int PLAYER_X    = 20;
   localparam int PSIZE       = 8;
   localparam int GROUND_Y    = 100;
   localparam int JUMP_H      = 24;
   localparam int FALL_STEP   = 4;
   localparam int SCROLL_STEP = 1;

   localparam colour_t COL_SKY    = 3'b011;
   localparam colour_t COL_GND_A  = 3'b010;
   localparam colour_t COL_GND_B  = 3'b110;
   localparam colour_t COL_PLAYER = 3'b100;
   localparam colour_t COL_NONE   = 3'b000;

   // Ground stripes alternate every 8 columns of the scrolled coordinate.
   function automatic colour_t ground_colour(input x_t bx, input logic [7:0] scroll);
      logic [7:0] sx;
      sx = bx + scroll;
      return sx[3] ? COL_GND_B : COL_GND_A;
   endfunction

endpackage

// File: rtl/game_datapath_if.sv
// rtl/game_datapath_if.sv - control strobes, status and pixel-write bundle between FSM and datapath
interface game_datapath_if;
   import game_pkg::*;

   logic    resetn;
   logic    drawB;
   logic    drawC;
   logic    plot;
   logic    enableX;
   logic    enableCountXC;
   logic    countUp;
   logic    countDown;
   logic    enableI;
   logic    doneP;
   logic    doneC;
   logic    ground;
   x_t      x;
   y_t      y;
   colour_t colour;
   logic    writeEn;

   modport master (
      output resetn, drawB, drawC, plot, enableX, enableCountXC,
             countUp, countDown, enableI,
      input  doneP, doneC, ground, x, y, colour, writeEn
   );

   modport slave (
      input  resetn, drawB, drawC, plot, enableX, enableCountXC,
             countUp, countDown, enableI,
      output doneP, doneC, ground, x, y, colour, writeEn
   );

endinterface

// File: rtl/xy_scan_counter.sv
// rtl/xy_scan_counter.sv - raster scan counter over a W x H area, column first, wraps after the last pixel
module xy_scan_counter #(
   parameter int W  = 160,
   parameter int H  = 120,
   parameter int XW = 8,
   parameter int YW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy,
   output logic          last
);

   logic x_end;
   logic y_end;

   assign x_end = (cx == XW'(W - 1));
   assign y_end = (cy == YW'(H - 1));
   assign last  = x_end && y_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cx <= '0;
         cy <= '0;
      end else if (clear) begin
         cx <= '0;
         cy <= '0;
      end else if (en) begin
         if (x_end) begin
            cx <= '0;
            cy <= y_end ? '0 : cy + 1'b1;
         end else begin
            cx <= cx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/game_datapath.sv
// rtl/game_datapath.sv - Mush-Jump datapath: background/player scans, jump physics, scroll and pixel output
module game_datapath
   import game_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   game_datapath_if.slave  bus
);

   localparam int   PXW     = $clog2(PSIZE);
   localparam y_t   PY_REST = y_t'(GROUND_Y - PSIZE);

   x_t             bx;
   y_t             by;
   logic [PXW-1:0] cx;
   logic [PXW-1:0] cy;
   logic           last_b;
   logic           last_c;
   y_t             py;
   logic [7:0]     scroll;
   y_t             py_up;
   y_t             py_dn;
   logic [7:0]     fall_sum;
   pixel_t         pix;

   xy_scan_counter #(.W(H_RES), .H(V_RES), .XW(8), .YW(7)) u_bg_scan (
      .clk   (clk),
      .reset (reset),
      .clear (bus.resetn),
      .en    (bus.enableX),
      .cx    (bx),
      .cy    (by),
      .last  (last_b)
   );

   xy_scan_counter #(.W(PSIZE), .H(PSIZE), .XW(PXW), .YW(PXW)) u_player_scan (
      .clk   (clk),
      .reset (reset),
      .clear (bus.resetn),
      .en    (bus.enableCountXC),
      .cx    (cx),
      .cy    (cy),
      .last  (last_c)
   );

   assign bus.doneP  = last_b;
   assign bus.doneC  = last_c;
   assign bus.ground = (py == PY_REST);

   assign fall_sum = {1'b0, py} + 8'(FALL_STEP);
   assign py_up    = (py >= y_t'(JUMP_H)) ? py - y_t'(JUMP_H) : '0;
   assign py_dn    = (fall_sum >= {1'b0, PY_REST}) ? PY_REST : fall_sum[6:0];

   // Opposing jump and fall strobes cancel rather than picking a winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         py <= PY_REST;
      end else if (bus.resetn) begin
         py <= PY_REST;
      end else if (bus.countUp && !bus.countDown) begin
         py <= py_up;
      end else if (bus.countDown && !bus.countUp) begin
         py <= py_dn;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scroll <= '0;
      end else if (bus.resetn) begin
         scroll <= '0;
      end else if (bus.enableI) begin
         scroll <= scroll + 8'(SCROLL_STEP);
      end
   end

   always_comb begin
      pix = '{x: '0, y: '0, colour: COL_NONE};
      if (bus.drawC) begin
         pix.x      = x_t'(PLAYER_X) + x_t'(cx);
         pix.y      = py + y_t'(cy);
         pix.colour = COL_PLAYER;
      end else if (bus.drawB) begin
         pix.x      = bx;
         pix.y      = by;
         pix.colour = (by < y_t'(GROUND_Y)) ? COL_SKY : ground_colour(bx, scroll);
      end
   end

   // Pixel is taken from the pre-edge counters, so a write and an advance can share a cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.x       <= '0;
         bus.y       <= '0;
         bus.colour  <= '0;
         bus.writeEn <= 1'b0;
      end else if (bus.resetn) begin
         bus.x       <= '0;
         bus.y       <= '0;
         bus.colour  <= '0;
         bus.writeEn <= 1'b0;
      end else begin
         bus.x       <= pix.x;
         bus.y       <= pix.y;
         bus.colour  <= pix.colour;
         bus.writeEn <= bus.plot;
      end
   end

endmodule

// File: tb/tb_game_datapath.sv
// tb/tb_game_datapath.sv - scoreboard bench for game_datapath scans, jump physics, scroll and resets
module tb_game_datapath;
   import game_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   game_datapath_if bus ();

   game_datapath dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pixel_t sb[$];
   int checks = 0;
   int errors = 0;

   // Every write the DUT emits must match the oldest expected pixel.
   always @(negedge clk) begin
      if (bus.writeEn === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_write got x=%0d y=%0d c=%b required no write", bus.x, bus.y, bus.colour);
         end else begin
            pixel_t e;
            e = sb.pop_front();
            if ({bus.x, bus.y, bus.colour} !== e) begin
               errors++;
               $display("FAIL sb_pixel got x=%0d y=%0d c=%b required x=%0d y=%0d c=%b",
                        bus.x, bus.y, bus.colour, e.x, e.y, e.colour);
            end
         end
      end
   end

   task automatic set_in(input logic b, c, p, ex, ec, up, dn, ei, rn);
      bus.drawB = b; bus.drawC = c; bus.plot = p; bus.enableX = ex;
      bus.enableCountXC = ec; bus.countUp = up; bus.countDown = dn;
      bus.enableI = ei; bus.resetn = rn;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int x, input int y, input logic [2:0] c);
      pixel_t p;
      p.x = x_t'(x); p.y = y_t'(y); p.colour = c;
      sb.push_back(p);
   endtask

   function automatic logic [2:0] bg_col(input int bx, input int by, input int scr);
      if (by < 100) return 3'b011;
      return ((((bx + scr) % 256) / 8) % 2) ? 3'b110 : 3'b010;
   endfunction

   task automatic do_reset();
      idle();
      reset = 1'b1;
      sb.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic pulse(input logic up, dn, ei, input int n);
      for (int i = 0; i < n; i++) begin
         set_in(0, 0, 0, 0, 0, up, dn, ei, 0);
         tick();
      end
      idle();
   endtask

   task automatic advance_bg(input int n);
      for (int i = 0; i < n; i++) begin
         set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
         tick();
      end
      idle();
   endtask

   task automatic check_py(input int exp_py);
      set_in(0, 1, 1, 0, 0, 0, 0, 0, 0);
      push(20, exp_py, 3'b100);
      tick();
      idle();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks += 7;
      if (bus.x !== 8'd0)      begin errors++; $display("FAIL reset_x got %0d required 0", bus.x); end
      if (bus.y !== 7'd0)      begin errors++; $display("FAIL reset_y got %0d required 0", bus.y); end
      if (bus.colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %b required 000", bus.colour); end
      if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL reset_writeEn got %b required 0", bus.writeEn); end
      if (bus.ground !== 1'b1) begin errors++; $display("FAIL reset_ground got %b required 1", bus.ground); end
      if (bus.doneP !== 1'b0)  begin errors++; $display("FAIL reset_doneP got %b required 0", bus.doneP); end
      if (bus.doneC !== 1'b0)  begin errors++; $display("FAIL reset_doneC got %b required 0", bus.doneC); end
   endtask

   task automatic test_bg_scan();
      int wcount = 0;
      do_reset();
      for (int i = 0; i < 19200; i++) begin
         set_in(1, 0, 1, 1, 0, 0, 0, 0, 0);
         push(i % 160, i / 160, bg_col(i % 160, i / 160, 0));
         checks++;
         if (bus.doneP !== (i == 19199)) begin
            errors++;
            $display("FAIL bg_doneP cycle %0d got %b required %b", i, bus.doneP, (i == 19199));
         end
         tick();
         if (bus.writeEn === 1'b1) wcount++;
         if (i == 50 * 160 + 5) begin
            checks++;
            if (bus.colour !== 3'b011) begin errors++; $display("FAIL bg_pixel_5_50 got %b required 011", bus.colour); end
         end
         if (i == 110 * 160 + 5) begin
            checks++;
            if (bus.colour !== 3'b010) begin errors++; $display("FAIL bg_pixel_5_110 got %b required 010", bus.colour); end
         end
      end
      idle();
      checks += 2;
      if (wcount != 19200) begin errors++; $display("FAIL bg_write_count got %0d required 19200", wcount); end
      if (bus.doneP !== 1'b0) begin errors++; $display("FAIL bg_wrap_doneP got %b required 0", bus.doneP); end
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
      push(0, 0, 3'b011);
      tick();
      idle();
      tick();
   endtask

   task automatic test_player_scan();
      do_reset();
      for (int i = 0; i < 64; i++) begin
         set_in(0, 1, 1, 0, 1, 0, 0, 0, 0);
         push(20 + i % 8, 92 + i / 8, 3'b100);
         checks++;
         if (bus.doneC !== (i == 63)) begin
            errors++;
            $display("FAIL player_doneC cycle %0d got %b required %b", i, bus.doneC, (i == 63));
         end
         tick();
      end
      idle();
      checks++;
      if (bus.doneC !== 1'b0) begin errors++; $display("FAIL player_wrap_doneC got %b required 0", bus.doneC); end
      tick();
   endtask

   task automatic test_jump_fall();
      do_reset();
      pulse(1, 0, 0, 1);
      check_py(68);
      checks++;
      if (bus.ground !== 1'b0) begin errors++; $display("FAIL jump_ground got %b required 0", bus.ground); end
      pulse(0, 1, 0, 6);
      check_py(92);
      checks++;
      if (bus.ground !== 1'b1) begin errors++; $display("FAIL fall_ground got %b required 1", bus.ground); end
      pulse(0, 1, 0, 1);
      check_py(92);
      checks++;
      if (bus.ground !== 1'b1) begin errors++; $display("FAIL fall_hold_ground got %b required 1", bus.ground); end
   endtask

   task automatic test_saturate_simul();
      do_reset();
      pulse(1, 0, 0, 4);
      check_py(0);
      checks++;
      if (bus.ground !== 1'b0) begin errors++; $display("FAIL sat_ground got %b required 0", bus.ground); end
      pulse(0, 1, 0, 1);
      check_py(4);
      pulse(1, 1, 0, 1);
      check_py(4);
   endtask

   task automatic test_scroll();
      do_reset();
      advance_bg(110 * 160);
      pulse(0, 0, 1, 8);
      for (int i = 0; i < 16; i++) begin
         set_in(1, 0, 1, 1, 0, 0, 0, 0, 0);
         push(i, 110, bg_col(i, 110, 8));
         tick();
         if (i == 0) begin
            checks++;
            if (bus.colour !== 3'b110) begin errors++; $display("FAIL scroll8_pixel_0_110 got %b required 110", bus.colour); end
         end
      end
      idle();
      pulse(0, 0, 1, 248);
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
      push(16, 110, 3'b010);
      tick();
      idle();
      checks++;
      if (bus.colour !== 3'b010) begin errors++; $display("FAIL scroll256_pixel_16_110 got %b required 010", bus.colour); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse(1, 0, 0, 1);
      advance_bg(60 * 160 + 80);
      set_in(1, 0, 1, 1, 0, 0, 0, 0, 0);
      push(80, 60, 3'b011);
      tick();
      idle();
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks += 6;
      if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL mid_reset_writeEn got %b required 0", bus.writeEn); end
      if (bus.x !== 8'd0)       begin errors++; $display("FAIL mid_reset_x got %0d required 0", bus.x); end
      if (bus.y !== 7'd0)       begin errors++; $display("FAIL mid_reset_y got %0d required 0", bus.y); end
      if (bus.colour !== 3'd0)  begin errors++; $display("FAIL mid_reset_colour got %b required 000", bus.colour); end
      if (bus.ground !== 1'b1)  begin errors++; $display("FAIL mid_reset_ground got %b required 1", bus.ground); end
      if (bus.doneP !== 1'b0)   begin errors++; $display("FAIL mid_reset_doneP got %b required 0", bus.doneP); end
      tick();
      checks++;
      if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL mid_reset_hold_writeEn got %b required 0", bus.writeEn); end
      reset = 1'b0;
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
      push(0, 0, 3'b011);
      tick();
      idle();
      tick();
      check_py(92);
   endtask

   task automatic test_resetn();
      do_reset();
      advance_bg(37);
      pulse(1, 0, 0, 1);
      set_in(1, 0, 1, 1, 0, 1, 0, 1, 1);
      tick();
      idle();
      checks += 2;
      if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL resetn_writeEn got %b required 0", bus.writeEn); end
      if (bus.ground !== 1'b1)  begin errors++; $display("FAIL resetn_ground got %b required 1", bus.ground); end
      check_py(92);
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
      push(0, 0, 3'b011);
      tick();
      idle();
      tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_bg_scan();
      test_player_scan();
      test_jump_fall();
      test_saturate_simul();
      test_scroll();
      test_reset_mid();
      test_resetn();
      repeat (2) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
